pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Front-end controller for the pipelined MIPS core.
- Decides each cycle whether the program counter register advances, holds or is redirected, and supplies its next value and write enable.
- Also generates the IF/ID hold/flush and ID/EX bubble controls.
- Resolves load-use hazards, jumps (resolved in ID), taken branches (resolved in EX) and instruction/data memory wait states. Redirects that arrive during a memory wait are captured and replayed.

Parameters:
- ADDR_W, 32: PC/target width.
- RESET_PC, 32'h0000_0000: value driven on pc_next_o during and right after reset.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pc_i  in  ADDR_W  current PC (program counter register output).
- if_id_rs_i  in  5  rs field of the instruction in ID.
- if_id_rt_i  in  5  rt field of the instruction in ID.
- id_ex_rt_i  in  5  destination rt of the instruction in EX.
- id_ex_memread_i  in  1  instruction in EX is a load.
- jump_i  in  1  jump decoded in ID.
- jump_target_i  in  ADDR_W  jump target.
- branch_taken_i  in  1  branch in EX resolved taken.
- branch_target_i  in  ADDR_W  branch target.
- imem_ready_i  in  1  instruction fetch completes this cycle.
- dmem_ready_i  in  1  data access completes this cycle; tie high when idle.
- pc_next_o  out  ADDR_W  next PC value.
- pc_write_o  out  1  PC register write enable.
- if_id_write_o  out  1  IF/ID register write enable.
- if_id_flush_o  out  1  zero the IF/ID register.
- id_ex_bubble_o  out  1  insert NOP into ID/EX.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (rst_i low, asynchronous): state=RUN, pend_valid=0, pend_target=0. Outputs: pc_next_o=RESET_PC, pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_bubble_o=1.
- Outputs are combinational from current state, registered pending target and inputs. There is zero-cycle latency from hazard inputs to controls.
- States: RUN=0, WAIT=1, REPLAY=2. State 3 is illegal and recovers to RUN.
- Priority in RUN, highest first:
  - Memory wait: imem_ready_i=0 or dmem_ready_i=0 -> pc_write_o=0, if_id_write_o=0, no flush, go to WAIT. If branch_taken_i or jump_i is asserted in the same cycle: capture the target (branch beats jump), set pend_valid=1, assert the corresponding flush (branch: if_id_flush_o and id_ex_bubble_o; jump: if_id_flush_o).
  - Taken branch: pc_next_o=branch_target_i, pc_write_o=1, if_id_flush_o=1, id_ex_bubble_o=1. Any simultaneous jump_i is ignored because it is on the wrong path.
  - Jump: pc_next_o=jump_target_i, pc_write_o=1, if_id_flush_o=1.
  - Load-use: id_ex_memread_i=1, id_ex_rt_i!=0, and id_ex_rt_i equals if_id_rs_i or if_id_rt_i -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1 for exactly that cycle. There is no held state; the bubble clears memread.
  - Sequential: pc_next_o=pc_i+4 (modulo 2^ADDR_W, wraps at 32'hFFFF_FFFC to 0), pc_write_o=1, if_id_write_o=1.
- WAIT:
  - pc_write_o=0, if_id_write_o=0.
  - A branch_taken_i arriving here overwrites pend_target, sets pend_valid and asserts the branch flushes.
  - A jump_i is captured only when pend_valid=0.
  - Both readies high: if pend_valid, go to REPLAY; else go to RUN and perform the RUN decision that same cycle.
- REPLAY (one cycle): pc_next_o=pend_target, pc_write_o=1, if_id_flush_o=1, pend_valid cleared, go to RUN. If a ready drops in this cycle, stay in REPLAY with pc_write_o=0.
- Reset asserted in any state aborts immediately; a pending redirect is discarded.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- Defined: adds 32-bit output stall_cnt_o and 32-bit output flush_cnt_o, both reset to 0 and saturating at 32'hFFFF_FFFF.
  - stall_cnt_o increments every cycle pc_write_o=0 while rst_i is high.
  - flush_cnt_o increments every cycle if_id_flush_o=1 while rst_i is high.
- Not defined: ports absent, no counter logic.

Decomposition:
- Shared package pc_seq_pkg: state encoding constants (RUN, WAIT, REPLAY), PC increment constant 4, RESET_PC default, NOP/register-zero index constant.
- One sub-module: pc_seq_hazard. Purely combinational load-use compare producing lu_stall; it is reusable by the forwarding unit.

Test Plan:
- Reset release with pc_i=0, all readies=1, no hazards -> pc_next_o=4, pc_write_o=1, if_id_write_o=1, state_o=0.
- Load-use: id_ex_memread_i=1, id_ex_rt_i=5, if_id_rs_i=5 -> one cycle of pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. Then with memread=0 -> pc_next_o=pc_i+4. Repeat with id_ex_rt_i=0 -> no stall.
- Branch and jump in the same cycle: branch_target_i=0x100, jump_target_i=0x200 -> pc_next_o=0x100, if_id_flush_o=1, id_ex_bubble_o=1.
- imem_ready_i=0 for 3 cycles with branch_taken_i=1 (target 0x40) in the first -> 3 cycles of pc_write_o=0 in state 1. Then one REPLAY cycle with pc_next_o=0x40, pc_write_o=1, then RUN.
- Wrap: pc_i=0xFFFF_FFFC -> pc_next_o=0x0000_0000.
- Assert rst_i low mid-WAIT with pend_valid=1 -> outputs take reset values immediately. After release, state_o=0 and no replay occurs.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants and types for the PC sequencer front-end controller.
package pc_seq_pkg;

    // FSM encoding; the value 2'd3 is unused and recovers to ST_RUN.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPLAY = 2'd2
    } pc_state_e;

    // Byte distance between sequential instructions.
    localparam int unsigned PC_INC = 4;

    // Default fetch address out of reset.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // Register $zero: never a real load destination, so it never stalls.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pc_seq_hazard.sv
// Load-use hazard detector: flags when the instruction in ID reads the
// register that the load currently in EX is about to write.
// Purely combinational so the forwarding unit can reuse it.
module pc_seq_hazard
    import pc_seq_pkg::*;
(
    input  logic [4:0] if_id_rs_i,
    input  logic [4:0] if_id_rt_i,
    input  logic [4:0] id_ex_rt_i,
    input  logic       id_ex_memread_i,
    output logic       lu_stall_o
);

    // Compare the load destination against both source fields of ID.
    always_comb begin
        lu_stall_o = id_ex_memread_i
                     && (id_ex_rt_i != REG_ZERO)
                     && ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
    end

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: chooses each cycle whether the PC advances, holds or is
// redirected, and drives the IF/ID hold/flush and ID/EX bubble controls.
// Redirects seen during a memory wait are held and replayed afterwards.
// Optional build macro PC_SEQ_PERF_EN adds saturating stall/flush counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEF)
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [4:0]        if_id_rs_i,
    input  logic [4:0]        if_id_rt_i,
    input  logic [4:0]        id_ex_rt_i,
    input  logic              id_ex_memread_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              imem_ready_i,
    input  logic              dmem_ready_i,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              if_id_flush_o,
    output logic              id_ex_bubble_o,
    output logic [1:0]        state_o
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    pc_state_e         state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    logic              lu_stall;
    logic              mem_wait;
    logic              do_run;
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_next_c;
    logic              pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c;

    pc_seq_hazard u_hazard (
        .if_id_rs_i      (if_id_rs_i),
        .if_id_rt_i      (if_id_rt_i),
        .id_ex_rt_i      (id_ex_rt_i),
        .id_ex_memread_i (id_ex_memread_i),
        .lu_stall_o      (lu_stall)
    );

    assign mem_wait = !imem_ready_i || !dmem_ready_i;
    assign pc_seq   = pc_i + ADDR_W'(PC_INC);

    // Next-state and control decode; RUN priority is wait > branch > jump > load-use.
    always_comb begin
        state_d        = state_q;
        pend_valid_d   = pend_valid_q;
        pend_target_d  = pend_target_q;
        pc_next_c      = pc_seq;
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        do_run         = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (!mem_wait && !pend_valid_q) begin
                    // Nothing held: leave WAIT and decide as RUN this cycle.
                    do_run = 1'b1;
                end else begin
                    if (branch_taken_i) begin
                        pend_target_d  = branch_target_i;
                        pend_valid_d   = 1'b1;
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                    end else if (jump_i && !pend_valid_q) begin
                        pend_target_d  = jump_target_i;
                        pend_valid_d   = 1'b1;
                        if_id_flush_c  = 1'b1;
                    end
                    if (!mem_wait) begin
                        state_d = ST_REPLAY;
                    end
                end
            end
            ST_REPLAY: begin
                pc_next_c = pend_target_q;
                if (!mem_wait) begin
                    pc_write_c    = 1'b1;
                    if_id_flush_c = 1'b1;
                    pend_valid_d  = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            default: begin
                // ST_RUN, and recovery from the unused encoding.
                do_run = 1'b1;
            end
        endcase

        if (do_run) begin
            state_d = ST_RUN;
            if (mem_wait) begin
                state_d = ST_WAIT;
                if (branch_taken_i) begin
                    pend_target_d  = branch_target_i;
                    pend_valid_d   = 1'b1;
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (jump_i) begin
                    pend_target_d  = jump_target_i;
                    pend_valid_d   = 1'b1;
                    if_id_flush_c  = 1'b1;
                end
            end else if (branch_taken_i) begin
                pc_next_c      = branch_target_i;
                pc_write_c     = 1'b1;
                if_id_flush_c  = 1'b1;
                id_ex_bubble_c = 1'b1;
            end else if (jump_i) begin
                pc_next_c      = jump_target_i;
                pc_write_c     = 1'b1;
                if_id_flush_c  = 1'b1;
            end else if (lu_stall) begin
                id_ex_bubble_c = 1'b1;
            end else begin
                pc_write_c     = 1'b1;
                if_id_write_c  = 1'b1;
            end
        end
    end

    // State and held-redirect registers; reset discards any pending redirect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    // While reset is asserted the pipeline is frozen and flushed.
    always_comb begin
        pc_next_o      = rst_i ? pc_next_c      : RESET_PC;
        pc_write_o     = rst_i ? pc_write_c     : 1'b0;
        if_id_write_o  = rst_i ? if_id_write_c  : 1'b0;
        if_id_flush_o  = rst_i ? if_id_flush_c  : 1'b1;
        id_ex_bubble_o = rst_i ? id_ex_bubble_c : 1'b1;
        state_o        = state_q;
    end

`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating counters of PC-hold cycles and IF/ID flush cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (if_id_flush_o && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: single-cycle RUN vectors from a table,
// followed by hand-written multi-cycle wait/replay/reset sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [4:0]  rs, rt, ex_rt;
    logic        memread, jump, br, imem, dmem;
    logic [31:0] jt, bt;
    logic [31:0] pc_next;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  state;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i           (clk),
        .rst_i           (rst_n),
        .pc_i            (pc),
        .if_id_rs_i      (rs),
        .if_id_rt_i      (rt),
        .id_ex_rt_i      (ex_rt),
        .id_ex_memread_i (memread),
        .jump_i          (jump),
        .jump_target_i   (jt),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .imem_ready_i    (imem),
        .dmem_ready_i    (dmem),
        .pc_next_o       (pc_next),
        .pc_write_o      (pc_write),
        .if_id_write_o   (if_id_write),
        .if_id_flush_o   (if_id_flush),
        .id_ex_bubble_o  (id_ex_bubble),
        .state_o         (state)
`ifdef PC_SEQ_PERF_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs, rt, ex_rt;
        logic        memread, jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        imem, dmem;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic        e_pw, e_ifw, e_fl, e_bub;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cmp_now(input string tag, input logic cpc, input logic [31:0] epc,
                           input logic epw, input logic eifw, input logic efl,
                           input logic ebub, input logic [1:0] est);
        if (cpc) chk({tag, ".pc_next"}, pc_next, epc);
        chk({tag, ".pc_write"},    32'(pc_write),     32'(epw));
        chk({tag, ".if_id_write"}, 32'(if_id_write),  32'(eifw));
        chk({tag, ".flush"},       32'(if_id_flush),  32'(efl));
        chk({tag, ".bubble"},      32'(id_ex_bubble), 32'(ebub));
        chk({tag, ".state"},       32'(state),        32'(est));
    endtask

    // Compare mid-cycle, then move to just after the next rising edge.
    task automatic cyc(input string tag, input logic cpc, input logic [31:0] epc,
                       input logic epw, input logic eifw, input logic efl,
                       input logic ebub, input logic [1:0] est);
        @(negedge clk);
        cmp_now(tag, cpc, epc, epw, eifw, efl, ebub, est);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] p);
        pc = p; rs = 5'd1; rt = 5'd2; ex_rt = 5'd3; memread = 1'b0;
        jump = 1'b0; jt = 32'h0; br = 1'b0; bt = 32'h0;
        imem = 1'b1; dmem = 1'b1;
    endtask

    initial begin
        //             pc            rs  rt  exrt mr j  jt           br bt          im dm cpc e_pc         pw ifw fl bub st
        vecs[0] = '{32'h0000_0000, 5'd0, 5'd0, 5'd0, 0, 0, 32'h0,       0, 32'h0,       1, 1, 1, 32'h0000_0004, 1, 1, 0, 0, 2'd0};
        vecs[1] = '{32'h0000_0010, 5'd5, 5'd9, 5'd5, 1, 0, 32'h0,       0, 32'h0,       1, 1, 0, 32'h0,         0, 0, 0, 1, 2'd0};
        vecs[2] = '{32'h0000_0010, 5'd5, 5'd9, 5'd5, 0, 0, 32'h0,       0, 32'h0,       1, 1, 1, 32'h0000_0014, 1, 1, 0, 0, 2'd0};
        vecs[3] = '{32'h0000_0014, 5'd4, 5'd7, 5'd7, 1, 0, 32'h0,       0, 32'h0,       1, 1, 0, 32'h0,         0, 0, 0, 1, 2'd0};
        vecs[4] = '{32'h0000_0018, 5'd0, 5'd0, 5'd0, 1, 0, 32'h0,       0, 32'h0,       1, 1, 1, 32'h0000_001C, 1, 1, 0, 0, 2'd0};
        vecs[5] = '{32'h0000_001C, 5'd6, 5'd7, 5'd5, 1, 0, 32'h0,       0, 32'h0,       1, 1, 1, 32'h0000_0020, 1, 1, 0, 0, 2'd0};
        vecs[6] = '{32'h0000_0020, 5'd1, 5'd2, 5'd3, 0, 1, 32'h200,     1, 32'h100,     1, 1, 1, 32'h0000_0100, 1, 0, 1, 1, 2'd0};
        vecs[7] = '{32'h0000_0100, 5'd1, 5'd2, 5'd3, 0, 1, 32'h200,     0, 32'h0,       1, 1, 1, 32'h0000_0200, 1, 0, 1, 0, 2'd0};
        vecs[8] = '{32'hFFFF_FFFC, 5'd1, 5'd2, 5'd3, 0, 0, 32'h0,       0, 32'h0,       1, 1, 1, 32'h0000_0000, 1, 1, 0, 0, 2'd0};
        vecs[9] = '{32'h0000_0040, 5'd5, 5'd2, 5'd5, 1, 1, 32'h0000_0800, 0, 32'h0,     1, 1, 1, 32'h0000_0800, 1, 0, 1, 0, 2'd0};

        // Reset state.
        rst_n = 1'b0;
        idle(32'h0000_1234);
        #2;
        cmp_now("reset", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single-cycle RUN decisions.
        for (int i = 0; i < 10; i++) begin
            pc = vecs[i].pc; rs = vecs[i].rs; rt = vecs[i].rt; ex_rt = vecs[i].ex_rt;
            memread = vecs[i].memread; jump = vecs[i].jump; jt = vecs[i].jt;
            br = vecs[i].br; bt = vecs[i].bt; imem = vecs[i].imem; dmem = vecs[i].dmem;
            cyc($sformatf("vec%0d", i), vecs[i].chk_pc, vecs[i].e_pc, vecs[i].e_pw,
                vecs[i].e_ifw, vecs[i].e_fl, vecs[i].e_bub, vecs[i].e_st);
        end

        // imem wait of three cycles with a taken branch in the first, then replay.
        idle(32'h0000_0080);
        imem = 1'b0; br = 1'b1; bt = 32'h0000_0040;
        cyc("wb1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        br = 1'b0;
        cyc("wb2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        cyc("wb3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        imem = 1'b1;
        cyc("wb4", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        cyc("wb_replay", 1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        pc = 32'h0000_0040;
        cyc("wb_run", 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Jump captured in a dmem wait; a later jump is ignored; replay stalls once.
        idle(32'h0000_0050);
        dmem = 1'b0; jump = 1'b1; jt = 32'h0000_0300;
        cyc("wj1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        dmem = 1'b1; jt = 32'h0000_0999;
        cyc("wj2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        jump = 1'b0; dmem = 1'b0;
        cyc("wj_rstall", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
        dmem = 1'b1;
        cyc("wj_replay", 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);
        pc = 32'h0000_0300;
        cyc("wj_run", 1'b1, 32'h0000_0304, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // A branch during WAIT overwrites the held jump target.
        idle(32'h0000_0060);
        imem = 1'b0; jump = 1'b1; jt = 32'h0000_0500;
        cyc("wo1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        jump = 1'b0; br = 1'b1; bt = 32'h0000_0600;
        cyc("wo2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
        br = 1'b0; imem = 1'b1;
        cyc("wo3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
        cyc("wo_replay", 1'b1, 32'h0000_0600, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2);

        // WAIT with nothing held resumes with a same-cycle RUN decision.
        idle(32'h0000_0030);
        imem = 1'b0;
        cyc("wr1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        imem = 1'b1; jump = 1'b1; jt = 32'h0000_0900;
        cyc("wr2", 1'b1, 32'h0000_0900, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        idle(32'h0000_0900);
        cyc("wr3", 1'b1, 32'h0000_0904, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        // Reset during WAIT with a held branch discards it.
        idle(32'h0000_0020);
        imem = 1'b0; br = 1'b1; bt = 32'h0000_0700;
        cyc("rw1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        br = 1'b0; imem = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        cmp_now("rw_rst", 1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pc = 32'h0000_0020;
        cyc("rw_post1", 1'b1, 32'h0000_0024, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        pc = 32'h0000_0024;
        cyc("rw_post2", 1'b1, 32'h0000_0028, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard bound in case the run never reaches its summary.
    initial begin
        #100000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
